// File: rtl/parser_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
// Shared constants and types for the parser ingress stages. It holds the VLAN
// TPID and ctrl flag patterns, the bit offsets of the first-beat header fields,
// and the classifier FSM and routing encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package parser_pkg;

   // Raw tdata patterns. Wire bytes 0x81,0x00 land as 16'h0081 in lanes 12..13.
   localparam logic [15:0] VLAN_TPID   = 16'h0081;
   localparam logic [15:0] CTRL_FLAG   = 16'hf2f1;

   // Bit offsets of header fields within the first beat.
   localparam int          TPID_OFFSET = 96;
   localparam int          VID_OFFSET  = 112;
   localparam int          FLAG_OFFSET = 320;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      FWD_DATA   = 2'd1,
      FWD_CTRL   = 2'd2,
      DROP       = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      RT_DATA = 2'd0,
      RT_CTRL = 2'd1,
      RT_DROP = 2'd2
   } route_t;

endpackage

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// Single-entry valid/ready register slice. The slice can be emptied and
// refilled in the same cycle, so it sustains one beat per cycle. The output
// stays stable while it is valid and not yet accepted.
// Ports:
//   axis_clk, aresetn        clock, asynchronous active-low reset
//   s_valid/s_ready/s_payload   upstream handshake and payload
//   m_valid/m_ready/m_payload   downstream handshake and payload (registered)
// -----------------------------------------------------------------------------
module axis_reg_slice #(
   parameter int C_WIDTH = 8
) (
   input  logic               axis_clk,
   input  logic               aresetn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [C_WIDTH-1:0] s_payload,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [C_WIDTH-1:0] m_payload
);

   logic               valid_r;
   logic [C_WIDTH-1:0] payload_r;

   // The slice accepts when it is empty or when its content leaves this cycle.
   assign s_ready   = ~valid_r | m_ready;
   assign m_valid   = valid_r;
   assign m_payload = payload_r;

   // Occupancy and payload register.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         valid_r   <= 1'b0;
         payload_r <= {C_WIDTH{1'b0}};
      end else if (s_valid && s_ready) begin
         valid_r   <= 1'b1;
         payload_r <= s_payload;
      end else if (m_ready) begin
         valid_r   <= 1'b0;
      end else begin
         valid_r   <= valid_r;
      end
   end

endmodule

// File: rtl/pkt_vlan_classifier.sv
// -----------------------------------------------------------------------------
// pkt_vlan_classifier
// Ingress classifier placed upstream of the parser. It classifies each packet
// on its first beat and routes it as follows:
//   DATA (VLAN TPID, no ctrl flag)  -> register slice -> m_axis_* (back-pressured)
//   CTRL (VLAN TPID + ctrl flag)    -> registered ctrl_m_axis_* (no back-pressure)
//   DROP (no VLAN TPID)             -> discarded and counted in drop_cnt
// The VLAN ID of a DATA packet is latched when its first beat enters the slice.
// m_vlan_id_valid pulses on the cycle that first beat transfers out.
// Ports:
//   axis_clk, aresetn        clock, asynchronous active-low reset
//   s_axis_*                 ingress AXI-Stream
//   m_axis_*                 data stream to the parser
//   m_vlan_id(_valid)        VLAN ID of the current data packet, first-beat pulse
//   ctrl_m_axis_*            ctrl stream, one tvalid pulse per beat
//   drop_cnt                 saturating count of dropped packets
// -----------------------------------------------------------------------------
module pkt_vlan_classifier
   import parser_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 512,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_VLANID_WIDTH       = 12,
   parameter int C_DROP_CNT_WIDTH     = 32
) (
   input  logic                              axis_clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [C_VLANID_WIDTH-1:0]         m_vlan_id,
   output logic                              m_vlan_id_valid,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    ctrl_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   ctrl_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  ctrl_m_axis_tkeep,
   output logic                              ctrl_m_axis_tvalid,
   output logic                              ctrl_m_axis_tlast,
   output logic [C_DROP_CNT_WIDTH-1:0]       drop_cnt
);

   localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
   // The slice payload is {first, tlast, tkeep, tuser, tdata}.
   localparam int PAY_W  = 2 + KEEP_W + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH;

   state_t                              state_r, state_nxt_s;
   route_t                              class_s, route_s;
   logic                                tpid_hit_s, flag_hit_s, accept_s, first_s;
   logic                                slice_ready_s, slice_load_s, first_out_s;
   logic [C_VLANID_WIDTH-1:0]           vid_s, vlan_id_r;
   logic [PAY_W-1:0]                    slice_in_s, slice_out_s;
   logic [C_S_AXIS_DATA_WIDTH-1:0]      ctrl_tdata_r;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]     ctrl_tuser_r;
   logic [KEEP_W-1:0]                   ctrl_tkeep_r;
   logic                                ctrl_tvalid_r, ctrl_tlast_r;
   logic [C_DROP_CNT_WIDTH-1:0]         drop_cnt_r;

   assign tpid_hit_s = (s_axis_tdata[TPID_OFFSET +: 16] == VLAN_TPID);
   assign flag_hit_s = (s_axis_tdata[FLAG_OFFSET +: 16] == CTRL_FLAG);
   // The high nibble sits in lane 14 [3:0] and the low byte in lane 15.
   assign vid_s      = {s_axis_tdata[VID_OFFSET +: 4], s_axis_tdata[VID_OFFSET+8 +: 8]};
   assign class_s    = tpid_hit_s ? (flag_hit_s ? RT_CTRL : RT_DATA) : RT_DROP;
   assign first_s    = (state_r == WAIT_FIRST);

   // WAIT_FIRST obeys the slice rule even for ctrl/drop beats, so a held slice
   // stalls classification of the next packet.
   assign s_axis_tready = ((state_r == FWD_CTRL) || (state_r == DROP)) ? 1'b1 : slice_ready_s;
   assign accept_s      = s_axis_tvalid & s_axis_tready;
   assign slice_load_s  = accept_s & (route_s == RT_DATA);

   // Route selection for the current beat and FSM next state.
   always_comb begin
      state_nxt_s = state_r;
      route_s     = RT_DROP;
      case (state_r)
         WAIT_FIRST: begin
            route_s = class_s;
            if (accept_s && !s_axis_tlast) begin
               case (class_s)
                  RT_DATA: state_nxt_s = FWD_DATA;
                  RT_CTRL: state_nxt_s = FWD_CTRL;
                  default: state_nxt_s = DROP;
               endcase
            end else begin
               state_nxt_s = WAIT_FIRST;
            end
         end
         FWD_DATA: begin
            route_s = RT_DATA;
            if (accept_s && s_axis_tlast) state_nxt_s = WAIT_FIRST;
            else                          state_nxt_s = FWD_DATA;
         end
         FWD_CTRL: begin
            route_s = RT_CTRL;
            if (accept_s && s_axis_tlast) state_nxt_s = WAIT_FIRST;
            else                          state_nxt_s = FWD_CTRL;
         end
         DROP: begin
            route_s = RT_DROP;
            if (accept_s && s_axis_tlast) state_nxt_s = WAIT_FIRST;
            else                          state_nxt_s = DROP;
         end
         default: begin
            route_s     = RT_DROP;
            state_nxt_s = WAIT_FIRST;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) state_r <= WAIT_FIRST;
      else          state_r <= state_nxt_s;
   end

   assign slice_in_s = {first_s, s_axis_tlast, s_axis_tkeep, s_axis_tuser, s_axis_tdata};

   axis_reg_slice #(
      .C_WIDTH (PAY_W)
   ) u_data_slice (
      .axis_clk  (axis_clk),
      .aresetn   (aresetn),
      .s_valid   (slice_load_s),
      .s_ready   (slice_ready_s),
      .s_payload (slice_in_s),
      .m_valid   (m_axis_tvalid),
      .m_ready   (m_axis_tready),
      .m_payload (slice_out_s)
   );

   assign {first_out_s, m_axis_tlast, m_axis_tkeep, m_axis_tuser, m_axis_tdata} = slice_out_s;

   // The first-beat tag travels through the slice, so a stall of any length
   // yields exactly one pulse on the real transfer.
   assign m_vlan_id_valid = m_axis_tvalid & m_axis_tready & first_out_s;
   assign m_vlan_id       = vlan_id_r;

   // VLAN ID latch, loaded when a DATA first beat enters the slice.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn)                     vlan_id_r <= {C_VLANID_WIDTH{1'b0}};
      else if (slice_load_s && first_s) vlan_id_r <= vid_s;
      else                              vlan_id_r <= vlan_id_r;
   end

   // Ctrl stream register: tvalid pulses per beat, and the fields hold between beats.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         ctrl_tdata_r  <= {C_S_AXIS_DATA_WIDTH{1'b0}};
         ctrl_tuser_r  <= {C_S_AXIS_TUSER_WIDTH{1'b0}};
         ctrl_tkeep_r  <= {KEEP_W{1'b0}};
         ctrl_tlast_r  <= 1'b0;
         ctrl_tvalid_r <= 1'b0;
      end else if (accept_s && (route_s == RT_CTRL)) begin
         ctrl_tdata_r  <= s_axis_tdata;
         ctrl_tuser_r  <= s_axis_tuser;
         ctrl_tkeep_r  <= s_axis_tkeep;
         ctrl_tlast_r  <= s_axis_tlast;
         ctrl_tvalid_r <= 1'b1;
      end else begin
         ctrl_tvalid_r <= 1'b0;
      end
   end

   assign ctrl_m_axis_tdata  = ctrl_tdata_r;
   assign ctrl_m_axis_tuser  = ctrl_tuser_r;
   assign ctrl_m_axis_tkeep  = ctrl_tkeep_r;
   assign ctrl_m_axis_tlast  = ctrl_tlast_r;
   assign ctrl_m_axis_tvalid = ctrl_tvalid_r;

   // Saturating drop counter, bumped once per dropped packet on its first beat.
   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         drop_cnt_r <= {C_DROP_CNT_WIDTH{1'b0}};
      end else if (accept_s && first_s && (class_s == RT_DROP) &&
                   (drop_cnt_r != {C_DROP_CNT_WIDTH{1'b1}})) begin
         drop_cnt_r <= drop_cnt_r + {{(C_DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pkt_vlan_classifier.sv
// -----------------------------------------------------------------------------
// tb_pkt_vlan_classifier
// Scoreboard bench for pkt_vlan_classifier. Expected beats are pushed when a
// packet is driven. A negedge monitor pops and compares them when they appear
// on the data or ctrl stream.
// -----------------------------------------------------------------------------
module tb_pkt_vlan_classifier;

   typedef struct {
      logic [511:0] d;
      logic [127:0] u;
      logic [63:0]  k;
      logic         l;
      logic         f;
      logic [11:0]  v;
   } beat_t;

   logic          axis_clk = 1'b0;
   logic          aresetn;
   logic [511:0]  s_axis_tdata;
   logic [127:0]  s_axis_tuser;
   logic [63:0]   s_axis_tkeep;
   logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [511:0]  m_axis_tdata;
   logic [127:0]  m_axis_tuser;
   logic [63:0]   m_axis_tkeep;
   logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [11:0]   m_vlan_id;
   logic          m_vlan_id_valid;
   logic [511:0]  ctrl_m_axis_tdata;
   logic [127:0]  ctrl_m_axis_tuser;
   logic [63:0]   ctrl_m_axis_tkeep;
   logic          ctrl_m_axis_tvalid, ctrl_m_axis_tlast;
   logic [31:0]   drop_cnt;

   int            check_cnt = 0;
   int            error_cnt = 0;
   int            cyc = 0;
   int            xfer_last = 0;
   int            xfer_prev = 0;
   int            exp_drop = 0;
   beat_t         data_q[$];
   beat_t         ctrl_q[$];

   pkt_vlan_classifier dut (
      .axis_clk           (axis_clk),
      .aresetn            (aresetn),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tuser       (s_axis_tuser),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tready      (s_axis_tready),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tkeep       (m_axis_tkeep),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tready      (m_axis_tready),
      .m_vlan_id          (m_vlan_id),
      .m_vlan_id_valid    (m_vlan_id_valid),
      .ctrl_m_axis_tdata  (ctrl_m_axis_tdata),
      .ctrl_m_axis_tuser  (ctrl_m_axis_tuser),
      .ctrl_m_axis_tkeep  (ctrl_m_axis_tkeep),
      .ctrl_m_axis_tvalid (ctrl_m_axis_tvalid),
      .ctrl_m_axis_tlast  (ctrl_m_axis_tlast),
      .drop_cnt           (drop_cnt)
   );

   always #5 axis_clk = ~axis_clk;

   // Cycle counter, used to check the spacing between transfers.
   always @(posedge axis_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         error_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mk_hdr(input logic [15:0] tpid, input logic [11:0] vid,
                                           input logic [15:0] flag, input logic [31:0] salt);
      logic [511:0] d;
      d = {16{salt}};
      d[111:96]  = tpid;
      d[115:112] = vid[11:8];
      d[127:120] = vid[7:0];
      d[335:320] = flag;
      return d;
   endfunction

   function automatic beat_t mk_beat(input logic [511:0] d0, input int i, input int n);
      beat_t b;
      b.d = d0;
      b.d[511:480] = d0[511:480] ^ 32'(i);
      b.u = {4{32'h1000_0000 + 32'(i)}};
      b.l = (i == n - 1);
      b.k = b.l ? 64'h0000_00FF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      b.f = (i == 0);
      b.v = {d0[115:112], d0[127:120]};
      return b;
   endfunction

   // Holds the beat until the DUT accepts it. The bound is 100 cycles.
   task automatic send_beat(input beat_t b);
      bit acc;
      int n;
      s_axis_tdata  = b.d;
      s_axis_tuser  = b.u;
      s_axis_tkeep  = b.k;
      s_axis_tlast  = b.l;
      s_axis_tvalid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 100) begin
         @(negedge axis_clk);
         acc = s_axis_tready;
         @(posedge axis_clk);
         #1;
         n++;
      end
      if (!acc) check("send_timeout", 512'(acc), 512'(1));
      s_axis_tvalid = 1'b0;
   endtask

   // Classifies the packet from its first beat, pushes the expected beats and drives them.
   task automatic send_pkt(input logic [511:0] d0, input int n);
      beat_t b;
      bit    tpid, flag;
      tpid = (d0[111:96] == 16'h0081);
      flag = (d0[335:320] == 16'hf2f1);
      if (!tpid) exp_drop++;
      for (int i = 0; i < n; i++) begin
         b = mk_beat(d0, i, n);
         if (tpid && flag)  ctrl_q.push_back(b);
         else if (tpid)     data_q.push_back(b);
         send_beat(b);
      end
   endtask

   // Output monitor: compares every data transfer and ctrl pulse against the scoreboard.
   initial begin
      beat_t e;
      forever begin
         @(negedge axis_clk);
         if (m_axis_tvalid && m_axis_tready) begin
            xfer_prev = xfer_last;
            xfer_last = cyc;
            if (data_q.size() == 0) begin
               check("data_unexpected", 512'(1), 512'(0));
            end else begin
               e = data_q.pop_front();
               check("data_tdata", m_axis_tdata, e.d);
               check("data_tuser", 512'(m_axis_tuser), 512'(e.u));
               check("data_tkeep", 512'(m_axis_tkeep), 512'(e.k));
               check("data_tlast", 512'(m_axis_tlast), 512'(e.l));
               check("vid_valid", 512'(m_vlan_id_valid), 512'(e.f));
               if (e.f) check("vid", 512'(m_vlan_id), 512'(e.v));
            end
         end
         if (ctrl_m_axis_tvalid) begin
            if (ctrl_q.size() == 0) begin
               check("ctrl_unexpected", 512'(1), 512'(0));
            end else begin
               e = ctrl_q.pop_front();
               check("ctrl_tdata", ctrl_m_axis_tdata, e.d);
               check("ctrl_tuser", 512'(ctrl_m_axis_tuser), 512'(e.u));
               check("ctrl_tkeep", 512'(ctrl_m_axis_tkeep), 512'(e.k));
               check("ctrl_tlast", 512'(ctrl_m_axis_tlast), 512'(e.l));
            end
         end
      end
   end

   initial begin
      beat_t        b;
      logic [511:0] hold_d;
      logic [511:0] d0;
      int           n;

      aresetn       = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 512'd0;
      s_axis_tuser  = 128'd0;
      s_axis_tkeep  = 64'd0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      check("rst_s_tready", 512'(s_axis_tready), 512'(1));
      check("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
      check("rst_ctrl_tvalid", 512'(ctrl_m_axis_tvalid), 512'(0));
      check("rst_drop_cnt", 512'(drop_cnt), 512'(0));
      check("rst_vid", 512'(m_vlan_id), 512'(0));
      check("rst_vid_valid", 512'(m_vlan_id_valid), 512'(0));
      @(posedge axis_clk);
      #1 aresetn = 1'b1;
      @(posedge axis_clk);
      #1;

      // Test 1: 2-beat DATA packet with vid 12'h035. The last beat sits in the slice one cycle after acceptance.
      send_pkt(mk_hdr(16'h0081, 12'h035, 16'h0000, 32'hA1A1_0001), 2);
      check("t1_lat_valid", 512'(m_axis_tvalid), 512'(1));
      check("t1_lat_last", 512'(m_axis_tlast), 512'(1));
      repeat (2) @(posedge axis_clk);
      #1;

      // Test 2: the same packet with a 3-cycle downstream stall after the first beat.
      m_axis_tready = 1'b0;
      fork
         send_pkt(mk_hdr(16'h0081, 12'h035, 16'h0000, 32'hB2B2_0002), 2);
         begin
            n = 0;
            @(negedge axis_clk);
            while (!m_axis_tvalid && n < 50) begin
               @(negedge axis_clk);
               n++;
            end
            check("t2_wait_valid", 512'(m_axis_tvalid), 512'(1));
            hold_d = m_axis_tdata;
            for (int i = 0; i < 3; i++) begin
               check("t2_s_tready_low", 512'(s_axis_tready), 512'(0));
               check("t2_hold_data", m_axis_tdata, hold_d);
               check("t2_no_vid_pulse", 512'(m_vlan_id_valid), 512'(0));
               if (i < 2) @(negedge axis_clk);
            end
            @(posedge axis_clk);
            #1 m_axis_tready = 1'b1;
         end
      join
      repeat (3) @(posedge axis_clk);
      #1;

      // Test 3: 3-beat ctrl packet. There is no data output and drop_cnt does not change.
      send_pkt(mk_hdr(16'h0081, 12'h123, 16'hf2f1, 32'hC3C3_0003), 3);
      repeat (2) @(posedge axis_clk);
      #1;
      check("t3_ctrl_done", 512'(ctrl_q.size()), 512'(0));
      check("t3_drop_cnt", 512'(drop_cnt), 512'(exp_drop));

      // Test 4: 1-beat packet with the wrong TPID is dropped. The next VLAN packet is still forwarded.
      send_pkt(mk_hdr(16'h0008, 12'h077, 16'h0000, 32'hD4D4_0004), 1);
      check("t4_drop_cnt", 512'(drop_cnt), 512'(1));
      check("t4_drop_model", 512'(drop_cnt), 512'(exp_drop));
      send_pkt(mk_hdr(16'h0081, 12'hABC, 16'h0000, 32'hD4D4_0005), 2);
      repeat (3) @(posedge axis_clk);
      #1;

      // Test 5: back-to-back single-beat DATA packets with vids 12'h001 and 12'h002.
      send_pkt(mk_hdr(16'h0081, 12'h001, 16'h0000, 32'hE5E5_0006), 1);
      send_pkt(mk_hdr(16'h0081, 12'h002, 16'h0000, 32'hE5E5_0007), 1);
      repeat (3) @(posedge axis_clk);
      #1;
      check("t5_consecutive", 512'(xfer_last - xfer_prev), 512'(1));

      // Test 6: reset in the middle of a 4-beat DATA packet, with beat 2 held in the slice.
      d0 = mk_hdr(16'h0081, 12'h456, 16'h0000, 32'hF6F6_0008);
      b = mk_beat(d0, 0, 4);
      data_q.push_back(b);
      send_beat(b);
      @(posedge axis_clk);
      #1 m_axis_tready = 1'b0;
      send_beat(mk_beat(d0, 1, 4));
      check("t6_held", 512'(m_axis_tvalid), 512'(1));
      #2 aresetn = 1'b0;
      #1;
      exp_drop = 0;
      check("t6_rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
      check("t6_rst_m_tdata", m_axis_tdata, 512'(0));
      check("t6_rst_s_tready", 512'(s_axis_tready), 512'(1));
      check("t6_rst_drop_cnt", 512'(drop_cnt), 512'(0));
      check("t6_rst_vid", 512'(m_vlan_id), 512'(0));
      check("t6_rst_ctrl_tdata", ctrl_m_axis_tdata, 512'(0));
      repeat (2) @(posedge axis_clk);
      #1;
      aresetn       = 1'b1;
      m_axis_tready = 1'b1;
      @(posedge axis_clk);
      #1;
      // The remaining beats carry no TPID in place, so they are dropped as a new packet.
      d0 = mk_beat(d0, 2, 4).d;
      d0[111:96] = 16'h0000;
      send_pkt(d0, 2);
      check("t6_drop_cnt", 512'(drop_cnt), 512'(1));
      check("t6_drop_model", 512'(drop_cnt), 512'(exp_drop));

      repeat (5) @(posedge axis_clk);
      #1;
      check("end_data_q_empty", 512'(data_q.size()), 512'(0));
      check("end_ctrl_q_empty", 512'(ctrl_q.size()), 512'(0));

      $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
      $finish;
   end

endmodule
